// File: rtl/multi_cs4_pkg.sv
// -----------------------------------------------------------------------------
// multi_cs4_pkg
//   Shared widths for the 4x4 carry-save array multiplier.
//   OP_WIDTH  : operand width (4)
//   RES_WIDTH : registered product width, 2*OP_WIDTH+1 (9)
// -----------------------------------------------------------------------------
package multi_cs4_pkg;

   localparam int OP_WIDTH  = 4;
   localparam int RES_WIDTH = 2 * OP_WIDTH + 1;

endpackage : multi_cs4_pkg

// File: rtl/multi_cs4_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   One-bit full adder cell, used for both the carry-save rows and the final
//   ripple-carry adder of multi_cs4.
//   Ports:
//     a_i, b_i, cin_i : addend bits
//     s_o             : sum bit
//     cout_o          : carry-out bit
// -----------------------------------------------------------------------------
module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic cin_i,
   output logic s_o,
   output logic cout_o
);

   assign s_o    = a_i ^ b_i ^ cin_i;
   assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule : full_adder

// File: rtl/multi_cs4.sv
// -----------------------------------------------------------------------------
// multi_cs4
//   Unsigned 4x4 carry-save array multiplier with a registered 9-bit product.
//   A new operand pair is accepted every cycle; the product appears one clock
//   after the operands are sampled. No handshake, no enable.
//   Ports:
//     clk    : rising-edge clock
//     rst    : asynchronous, active-high reset (clears result)
//     a      : 4-bit unsigned multiplicand
//     b      : 4-bit unsigned multiplier
//     result : 9-bit registered product a*b (bit 8 is the final carry-out)
// -----------------------------------------------------------------------------
module multi_cs4
   import multi_cs4_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [OP_WIDTH-1:0]  a,
   input  logic [OP_WIDTH-1:0]  b,
   output logic [RES_WIDTH-1:0] result
);

   // pp[i][j] = a[j] & b[i]; row i carries weight i+j in column j.
   logic [OP_WIDTH-1:0][OP_WIDTH-1:0] pp;

   // Per-row sum and carry vectors of the carry-save array. Row 0 is the raw
   // partial-product row with no carries.
   logic [OP_WIDTH-1:0][OP_WIDTH-1:0] row_sum;
   logic [OP_WIDTH-1:0][OP_WIDTH-1:0] row_carry;

   // Final ripple adder operands/results.
   logic [OP_WIDTH-1:0] rca_x;
   logic [OP_WIDTH-1:0] rca_y;
   logic [OP_WIDTH-1:0] rca_s;
   logic [OP_WIDTH:0]   rca_c;

   logic [RES_WIDTH-1:0] result_d;
   logic [RES_WIDTH-1:0] result_q;

   always_comb begin
      pp = '0;
      for (int i = 0; i < OP_WIDTH; i++) begin
         for (int j = 0; j < OP_WIDTH; j++) begin
            pp[i][j] = a[j] & b[i];
         end
      end
   end

   assign row_sum[0]   = pp[0];
   assign row_carry[0] = '0;

   // Cell (i,j) adds three bits of weight i+j: the row's partial product,
   // the previous row's sum one column to the left (its column j+1), and the
   // previous row's carry from column j. Carries move down, never sideways.
   for (genvar i = 1; i < OP_WIDTH; i++) begin : g_row
      for (genvar j = 0; j < OP_WIDTH; j++) begin : g_col
         logic shifted_sum;
         if (j == OP_WIDTH - 1) begin : g_msb
            // Nothing of weight i+3 leaves the previous row as a sum.
            assign shifted_sum = 1'b0;
         end else begin : g_inner
            assign shifted_sum = row_sum[i-1][j+1];
         end
         full_adder u_fa (
            .a_i    (pp[i][j]),
            .b_i    (shifted_sum),
            .cin_i  (row_carry[i-1][j]),
            .s_o    (row_sum[i][j]),
            .cout_o (row_carry[i][j])
         );
      end
   end

   // Last row: sums of weight 4..6 (column 1..3) and carries of weight 4..7
   // are merged by a plain 4-bit ripple adder.
   assign rca_x    = {1'b0, row_sum[OP_WIDTH-1][OP_WIDTH-1:1]};
   assign rca_y    = row_carry[OP_WIDTH-1];
   assign rca_c[0] = 1'b0;

   for (genvar k = 0; k < OP_WIDTH; k++) begin : g_rca
      full_adder u_fa (
         .a_i    (rca_x[k]),
         .b_i    (rca_y[k]),
         .cin_i  (rca_c[k]),
         .s_o    (rca_s[k]),
         .cout_o (rca_c[k+1])
      );
   end

   // Bits 0..3 are the low sum bit of each row; bit 8 is the ripple carry-out,
   // which is never set for 4-bit operands but stays a real signal.
   assign result_d = {rca_c[OP_WIDTH], rca_s,
                      row_sum[3][0], row_sum[2][0], row_sum[1][0], row_sum[0][0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q <= '0;
      end else begin
         result_q <= result_d;
      end
   end

   assign result = result_q;

endmodule : multi_cs4

// File: tb/tb_multi_cs4.sv
// -----------------------------------------------------------------------------
// tb_multi_cs4
//   Self-checking bench for multi_cs4. A reference model pushes the
//   arithmetic product of the operands seen at each rising edge into an
//   expected queue; a compare process checks result against it on every
//   falling edge. Directed steps add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_multi_cs4;

   logic       clk;
   logic       rst;
   logic [3:0] a;
   logic [3:0] b;
   logic [8:0] result;

   int checks = 0;
   int errors = 0;

   logic [8:0] exp_q[$];

   multi_cs4 u_dut (
      .clk    (clk),
      .rst    (rst),
      .a      (a),
      .b      (b),
      .result (result)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- checking helper ----------------
   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Product of the operands present at each edge, in plain integer arithmetic.
   always @(posedge clk) begin
      if (!rst) begin
         exp_q.push_back(9'(int'(a) * int'(b)));
      end
   end

   // Any reset discards whatever product was pending.
   always @(posedge rst) begin
      exp_q.delete();
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      logic [8:0] e;
      if (rst === 1'b1) begin
         check("model_rst", result, 9'd0);
      end else if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("model_prod", result, e);
         check("model_bit8", {8'd0, result[8]}, 9'd0);
      end else begin
         // Released from reset but no edge yet: nothing stale may show.
         check("model_idle", result, 9'd0);
      end
   end

   // ---------------- driver ----------------
   task automatic apply_and_check(input logic [3:0] av, input logic [3:0] bv,
                                  input logic [8:0] exp, input string name);
      @(negedge clk);
      #1;
      a = av;
      b = bv;
      @(posedge clk);
      #1;
      check(name, result, exp);
   endtask

   initial begin
      rst = 1'b1;
      a   = 4'd3;
      b   = 4'd4;
      #1;
      check("reset_immediate", result, 9'd0);
      @(posedge clk);
      #1;
      check("reset_hold_1", result, 9'd0);
      @(posedge clk);
      #1;
      check("reset_hold_2", result, 9'd0);

      @(negedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("reset_release_3x4", result, 9'd12);

      // Directed products, back-to-back.
      apply_and_check(4'd3,  4'd4,  9'd12,  "dir_3x4");
      apply_and_check(4'd10, 4'd7,  9'd70,  "dir_10x7");
      apply_and_check(4'd9,  4'd14, 9'd126, "dir_9x14");
      apply_and_check(4'd6,  4'd6,  9'd36,  "dir_6x6");

      // Boundaries.
      apply_and_check(4'd0,  4'd15, 9'd0,   "bnd_0x15");
      apply_and_check(4'd15, 4'd0,  9'd0,   "bnd_15x0");
      apply_and_check(4'd1,  4'd15, 9'd15,  "bnd_1x15");
      apply_and_check(4'd15, 4'd15, 9'd225, "bnd_15x15");
      check("bnd_15x15_bit8", {8'd0, result[8]}, 9'd0);

      // Exhaustive sweep, one pair per cycle; the compare process checks each.
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            #1;
            a = 4'(i);
            b = 4'(j);
         end
      end

      // Mid-stream reset while 15x15 is showing.
      apply_and_check(4'd15, 4'd15, 9'd225, "mid_before");
      #1;
      rst = 1'b1;
      #1;
      check("mid_async_clear", result, 9'd0);
      #1;
      rst = 1'b0;
      #1;
      check("mid_after_release", result, 9'd0);
      @(posedge clk);
      #1;
      check("mid_first_edge", result, 9'd225);

      // Operands changing between edges: only the value at the edge counts.
      @(negedge clk);
      #1;
      a = 4'd5;
      b = 4'd5;
      #2;
      a = 4'd7;
      b = 4'd3;
      @(posedge clk);
      #1;
      check("hold_7x3", result, 9'd21);

      // Held until the next edge.
      #3;
      check("hold_between_edges", result, 9'd21);

      @(negedge clk);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_multi_cs4
